// File: rtl/shift_unit_mc_pkg.sv
// ---------------------------------------------------------------------------
// shift_unit_mc_pkg
// Shared constants and types for the multicycle shifter.
//   DATA_WIDTH  : operand/result width (only 32 is supported)
//   SHAMT_WIDTH : shift-amount width, log2(DATA_WIDTH)
//   IDX_WIDTH   : width of the stage index (stages 4..0)
//   op_e        : OP_SLL (zero fill) / OP_SRA (sign fill)
//   state_e     : sequencer states IDLE / SHIFT / DONE
// ---------------------------------------------------------------------------
package shift_unit_mc_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int SHAMT_WIDTH = 5;
  localparam int IDX_WIDTH   = 3;

  // Index of the first (largest, 16-bit) stage.
  localparam logic [IDX_WIDTH-1:0] IDX_FIRST = IDX_WIDTH'(SHAMT_WIDTH - 1);

  typedef enum logic {
    OP_SLL = 1'b0,
    OP_SRA = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : shift_unit_mc_pkg

// File: rtl/shift_unit_mc_if.sv
// ---------------------------------------------------------------------------
// shift_unit_mc_if
// Request/result bundle of the multicycle shifter.
//   start, ctrl_op, ctrl_shiftamt, data_operandA : request (master -> slave)
//   data_result, data_resultRDY, busy            : result  (slave -> master)
// Modports: master = requester (ALU / testbench), slave = shift_unit_mc.
// ---------------------------------------------------------------------------
interface shift_unit_mc_if;
  import shift_unit_mc_pkg::*;

  logic                   start;
  op_e                    ctrl_op;
  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt;
  logic [DATA_WIDTH-1:0]  data_operandA;
  logic [DATA_WIDTH-1:0]  data_result;
  logic                   data_resultRDY;
  logic                   busy;

  modport master (
    output start, ctrl_op, ctrl_shiftamt, data_operandA,
    input  data_result, data_resultRDY, busy
  );

  modport slave (
    input  start, ctrl_op, ctrl_shiftamt, data_operandA,
    output data_result, data_resultRDY, busy
  );

endinterface : shift_unit_mc_if

// File: rtl/shift_unit_mc_stage.sv
// ---------------------------------------------------------------------------
// shift_stage_pow2
// One shared power-of-two shift stage (combinational).
//   i_acc      : current accumulator
//   i_idx      : stage index; shift distance is 2^i_idx (0..4)
//   i_op       : OP_SLL shifts left with zero fill, OP_SRA shifts right with
//                copies of i_acc[31]
//   i_enable   : when low the accumulator passes through unchanged
//   o_next_acc : accumulator after this stage
// ---------------------------------------------------------------------------
module shift_stage_pow2
  import shift_unit_mc_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_acc,
  input  logic [IDX_WIDTH-1:0]  i_idx,
  input  op_e                   i_op,
  input  logic                  i_enable,
  output logic [DATA_WIDTH-1:0] o_next_acc
);

  logic [SHAMT_WIDTH-1:0] w_dist;

  assign w_dist = SHAMT_WIDTH'(1) << i_idx;

  // NOTE: o_next_acc is assigned a default before any branch so this block
  // can never infer a latch.
  always_comb begin
    o_next_acc = i_acc;
    if (i_enable) begin
      if (i_op == OP_SRA) begin
        o_next_acc = DATA_WIDTH'($signed(i_acc) >>> w_dist);
      end else begin
        o_next_acc = i_acc << w_dist;
      end
    end
  end

endmodule : shift_stage_pow2

// File: rtl/shift_unit_mc.sv
// ---------------------------------------------------------------------------
// shift_unit_mc
// Multicycle 32-bit SLL / SRA. Walks the 16/8/4/2/1 stages, one per cycle,
// MSB of the shift amount first, through one shared stage datapath. Fixed
// 5-cycle latency from accepted start to the one-cycle data_resultRDY pulse.
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : shift_unit_mc_if.slave (start/ctrl/operand in, result/RDY/busy out)
// ---------------------------------------------------------------------------
module shift_unit_mc
  import shift_unit_mc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  shift_unit_mc_if.slave    bus
);

  state_e                 r_state;
  logic [DATA_WIDTH-1:0]  r_acc;
  logic [SHAMT_WIDTH-1:0] r_amt;
  op_e                    r_op;
  logic [IDX_WIDTH-1:0]   r_idx;
  logic [DATA_WIDTH-1:0]  r_result;
  logic                   r_rdy;
  logic                   r_busy;

  logic [DATA_WIDTH-1:0]  w_next_acc;

  shift_stage_pow2 u_stage (
    .i_acc      (r_acc),
    .i_idx      (r_idx),
    .i_op       (r_op),
    .i_enable   (r_amt[r_idx]),
    .o_next_acc (w_next_acc)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_amt    <= '0;
      r_op     <= OP_SLL;
      r_idx    <= '0;
      r_result <= '0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      // RDY is a single-cycle pulse; only the last stage raises it.
      r_rdy <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          // Operands are captured only here; later input changes are ignored.
          if (bus.start) begin
            r_acc   <= bus.data_operandA;
            r_amt   <= bus.ctrl_shiftamt;
            r_op    <= bus.ctrl_op;
            r_idx   <= IDX_FIRST;
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_acc <= w_next_acc;
          if (r_idx != '0) begin
            r_idx <= r_idx - IDX_WIDTH'(1);
          end else begin
            r_result <= w_next_acc;
            r_rdy    <= 1'b1;
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = r_busy;

endmodule : shift_unit_mc

// File: doc/shift_unit_mc.md
Name: shift_unit_mc

Overview:
- Multicycle 32-bit logical-left / arithmetic-right shifter for the ALU shift path.
- Sequences the fixed power-of-two shift stages (16, 8, 4, 2, 1): one stage per cycle, MSB of shift amount first.
- Produces a registered result with a one-cycle ready pulse for the ALU result mux and the writeback stage.
- Trades four extra cycles of latency for one shared stage datapath instead of a five-level combinational barrel.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- SHAMT_WIDTH, 5, shift-amount width; must equal log2(DATA_WIDTH).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clock.
- start  input  1  request; accepted only in IDLE or DONE.
- ctrl_op  input  1  0 = SLL (zero fill), 1 = SRA (sign fill from bit 31).
- ctrl_shiftamt  input  SHAMT_WIDTH  shift amount, 0..31.
- data_operandA  input  DATA_WIDTH  value to shift.
- data_result  output  DATA_WIDTH  registered result; holds until the next completion.
- data_resultRDY  output  1  one-cycle pulse: data_result is valid and new.
- busy  output  1  high in SHIFT; start is ignored while high.

Behaviour:
- Reset (reset low at a rising edge):
  - state = IDLE, data_result = 0, data_resultRDY = 0, busy = 0.
  - Internal accumulator, amount, op and stage index all clear to 0.
  - Reset overrides start and aborts any in-flight operation with no RDY pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 loads acc <= data_operandA, amt <= ctrl_shiftamt, op <= ctrl_op, idx <= 4; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one edge per stage:
  - If amt[idx] = 1, acc <= acc shifted by 2^idx in direction op; otherwise acc is unchanged.
  - SRA fills vacated high bits with acc[31]. SLL fills vacated low bits with 0.
  - If idx > 0: idx <= idx - 1 and stay in SHIFT.
  - If idx = 0: data_result <= final acc, data_resultRDY <= 1, go to DONE.
- DONE (lasts exactly one cycle, with data_resultRDY = 1):
  - start = 1 loads a new operation exactly as in IDLE and goes to SHIFT.
  - Otherwise go to IDLE.
  - data_resultRDY falls on the next edge in both cases.
- Latency and throughput:
  - Start sampled at edge E0 gives data_resultRDY high during the cycle after edge E5 (5-cycle latency).
  - The latency is fixed and independent of shift amount; shamt = 0 still takes 5 cycles and returns the operand unchanged.
  - Back-to-back issue: one result every 6 cycles when start is reasserted in the DONE cycle.
- Inputs are sampled only at acceptance; changes to operand, op or shamt during SHIFT have no effect.
- start during SHIFT is ignored and not queued.
- busy = (state == SHIFT), registered and consistent with state.
- SRA of a negative value by 31 gives 0xFFFFFFFF. SRA of a positive value by 31 gives 0. No saturation, no overflow flag.

Decomposition:
- Shared package:
  - Op encodings OP_SLL = 0, OP_SRA = 1.
  - State encoding (IDLE/SHIFT/DONE).
  - DATA_WIDTH and SHAMT_WIDTH constants.
- One combinational sub-module, shift_stage_pow2:
  - Inputs: acc, idx, op, enable. Output: next acc.
  - Implements the 2^idx shift in both directions with the correct fill.
- The FSM, counters and result register live in shift_unit_mc.

Test Plan:
- SRA 0x80000000 by 8, start at E0 -> data_resultRDY only during the cycle after E5; data_result = 0xFF800000.
- SLL 0x00000001 by 31 -> 0x80000000; SRA 0x7FFFFFFF by 31 -> 0x00000000; SRA 0xF0000000 by 31 -> 0xFFFFFFFF.
- shamt = 0, op SRA, operand 0x12345678 -> 0x12345678 after the same 5-cycle latency.
- Start SLL 0x0000000F by 4, then pulse start with other operands at E2 and E3 -> the extra starts are ignored; one RDY pulse; result 0x000000F0.
- Assert start in the DONE cycle with SRA 0xFFFF0000 by 16 -> first result 0x000000F0 held; second RDY 6 cycles after the first; result 0xFFFFFFFF.
- Drive reset low at E3 of an operation -> next cycle busy = 0, data_result = 0, no RDY pulse; a fresh start afterwards completes normally.
